if_fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS 5-stage pipeline, directly upstream of the ID-stage controller. Owns the fetch PC and runs a req/ack handshake with variable-latency instruction memory, one request in flight at a time. Buffers returned words in a small FIFO and presents a registered {inst, pc, pc+4, valid} to ID. Obeys the controller's if_en (stall) and if_rst (flush), and takes branch/jump redirects from EXE.

---
 rtl/if_fetch_stage_pkg.sv | 19 +
 rtl/if_fetch_stage_fifo.sv | 48 ++++
 rtl/if_fetch_stage.sv | 130 +++++++++++++
 tb/tb_if_fetch_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM encoding,
// fetch-buffer entry layout and reset defaults.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

  localparam logic [31:0] INST_NOP         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_stage_fifo.sv
// Fetch buffer: power-of-two circular FIFO of {pc, inst} entries with a
// synchronous flush. Push and pop in the same cycle are legal even when full.
module if_fetch_fifo
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic [AW:0]  count,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // When full, wr_ptr == rd_ptr: the head is read before this edge overwrites it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: owns the fetch PC, runs one-outstanding req/ack to instruction
// memory, buffers returned words and presents a registered {inst, pc, pc+4, valid} to ID.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_en,
  input  logic        if_rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_next,
  output logic        if_valid,
  output logic        misaligned,
  output if_state_e   state_dbg
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  if_state_e    state;
  logic [31:0]  fetch_pc;
  logic [31:0]  stale_pc;
  logic [31:0]  new_pc;
  logic         flush;
  logic         push;
  logic         pop;
  logic [AW:0]  count;
  logic [AW:0]  count_next;
  logic         empty;
  fetch_entry_t head;
  fetch_entry_t wdata;

  // Handshake: imem_req/imem_addr come straight from registers, so they hold
  // steady until the edge where imem_ack is sampled (with imem_rdata);
  // an ack seen while imem_req=0 (IDLE) is ignored.
  assign imem_req   = (state != IF_IDLE);
  assign imem_addr  = (state == IF_DRAIN) ? stale_pc : fetch_pc;
  assign state_dbg  = state;

  assign flush      = if_rst | redirect;
  assign new_pc     = redirect ? {redirect_pc[31:2], 2'b00} : fetch_pc;
  assign push       = (state == IF_REQ) & imem_ack & ~flush;
  assign pop        = if_en & ~empty & ~flush;
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  assign wdata      = '{pc: fetch_pc, inst: imem_rdata};

  if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .count (count),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IF_IDLE;
      fetch_pc   <= RESET_PC;
      stale_pc   <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      misaligned <= redirect & (redirect_pc[1:0] != 2'b00);
      case (state)
        IF_IDLE: begin
          if (flush) begin
            fetch_pc <= new_pc;
            state    <= IF_REQ;
          end else if (count_next < DEPTH_C) begin
            state <= IF_REQ;
          end
        end
        IF_REQ: begin
          if (flush) begin
            fetch_pc <= new_pc;
            if (!imem_ack) begin
              stale_pc <= fetch_pc;
              state    <= IF_DRAIN;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (count_next >= DEPTH_C) state <= IF_IDLE;
          end
        end
        IF_DRAIN: begin
          // Orphaned request still in flight; its data is dropped on ack.
          fetch_pc <= new_pc;
          if (imem_ack) state <= IF_REQ;
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst       <= INST_NOP;
      id_pc      <= 32'h0;
      id_pc_next <= 32'd4;
      if_valid   <= 1'b0;
    end else if (flush) begin
      inst     <= INST_NOP;
      if_valid <= 1'b0;
    end else if (if_en) begin
      if (!empty) begin
        inst       <= head.inst;
        id_pc      <= head.pc;
        id_pc_next <= head.pc + 32'd4;
        if_valid   <= 1'b1;
      end else begin
        inst     <= INST_NOP;
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: latency-programmable memory responder
// (word = 0x1000_0000 | addr) and hand-computed checks after each edge.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_en;
  logic        if_rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_next;
  logic        if_valid;
  logic        misaligned;
  if_state_e   state_dbg;

  int   total = 0;
  int   bad   = 0;
  int   lat   = 0;
  int   wcnt  = 0;
  logic force_ack = 1'b0;

  if_fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_en       (if_en),
    .if_rst      (if_rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .id_pc       (id_pc),
    .id_pc_next  (id_pc_next),
    .if_valid    (if_valid),
    .misaligned  (misaligned),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory responder: ack after lat waiting cycles of a held request
  assign imem_ack   = force_ack | (imem_req && (wcnt >= lat));
  assign imem_rdata = 32'h1000_0000 | imem_addr;

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    rst = 1'b0; if_rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b0; if_en = 1'b1; if_rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // ---- 1: reset values, then zero-wait streaming
    lat = 0;
    hold_reset();
    check("rst_req", imem_req, 1'b0);
    check("rst_state", state_dbg, IF_IDLE);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", id_pc, 32'h0);
    check("rst_pcn", id_pc_next, 32'h4);
    check("rst_valid", if_valid, 1'b0);
    check("rst_mis", misaligned, 1'b0);
    rst = 1'b1;
    tick(); // E1
    check("s1_req", imem_req, 1'b1);
    check("s1_addr0", imem_addr, 32'h0);
    tick(); // E2
    check("s1_addr4", imem_addr, 32'h4);
    check("s1_valid_e2", if_valid, 1'b0);
    tick(); // E3
    check("s1_valid_e3", if_valid, 1'b1);
    check("s1_inst0", inst, 32'h1000_0000);
    check("s1_pc0", id_pc, 32'h0);
    check("s1_pcn0", id_pc_next, 32'h4);
    check("s1_addr8", imem_addr, 32'h8);
    tick(); // E4
    check("s1_pc4", id_pc, 32'h4);
    check("s1_inst4", inst, 32'h1000_0004);
    tick(); // E5
    check("s1_pc8", id_pc, 32'h8);
    tick(); // E6
    check("s1_pc12", id_pc, 32'hC);
    check("s1_valid_e6", if_valid, 1'b1);
    check("s1_addr20", imem_addr, 32'h14);

    // ---- 2: stall from reset, FIFO fills to 2 then IDLE, resume without gaps
    if_en = 1'b0;
    hold_reset();
    rst = 1'b1;
    tick(); tick(); tick(); // E1..E3
    check("s2_req_idle", imem_req, 1'b0);
    check("s2_state_idle", state_dbg, IF_IDLE);
    tick(); tick(); tick(); tick(); tick(); // E4..E8
    check("s2_req_hold", imem_req, 1'b0);
    check("s2_valid_hold", if_valid, 1'b0);
    check("s2_inst_hold", inst, 32'h0);
    if_en = 1'b1;
    tick(); // E9
    check("s2_pc0", id_pc, 32'h0);
    check("s2_valid0", if_valid, 1'b1);
    check("s2_addr8", imem_addr, 32'h8);
    check("s2_req_on", imem_req, 1'b1);
    tick(); // E10
    check("s2_pc4", id_pc, 32'h4);
    tick(); // E11
    check("s2_pc8", id_pc, 32'h8);
    check("s2_valid8", if_valid, 1'b1);
    tick(); // E12
    check("s2_pc12", id_pc, 32'hC);

    // ---- 3: 3-cycle latency, redirect while request to 0x8 is waiting
    lat = 3;
    hold_reset();
    rst = 1'b1;
    repeat (6) tick(); // E1..E6
    check("s3_pc0", id_pc, 32'h0);
    check("s3_valid0", if_valid, 1'b1);
    tick(); // E7
    check("s3_bubble", if_valid, 1'b0);
    tick(); tick(); tick(); // E8..E10
    check("s3_pc4", id_pc, 32'h4);
    check("s3_addr8", imem_addr, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick(); // E11
    redirect = 1'b0;
    check("s3_drain", state_dbg, IF_DRAIN);
    check("s3_drain_addr", imem_addr, 32'h8);
    check("s3_flush_valid", if_valid, 1'b0);
    tick(); // E12
    check("s3_drain_hold", imem_addr, 32'h8);
    check("s3_drain_req", imem_req, 1'b1);
    tick(); // E13
    check("s3_addr100", imem_addr, 32'h100);
    check("s3_state_req", state_dbg, IF_REQ);
    check("s3_no8_a", if_valid, 1'b0);
    tick(); tick(); tick(); tick(); // E14..E17
    check("s3_no8_b", if_valid, 1'b0);
    tick(); // E18
    check("s3_pc100", id_pc, 32'h100);
    check("s3_inst100", inst, 32'h1000_0100);
    check("s3_pcn104", id_pc_next, 32'h104);
    check("s3_valid100", if_valid, 1'b1);

    // ---- 4: misaligned redirect on the same cycle as ack for 0xC
    lat = 0;
    hold_reset();
    rst = 1'b1;
    tick(); tick(); tick(); tick(); // E1..E4
    check("s4_addrC", imem_addr, 32'hC);
    check("s4_pc4", id_pc, 32'h4);
    redirect = 1'b1; redirect_pc = 32'h203;
    tick(); // E5
    redirect = 1'b0; redirect_pc = 32'h0;
    check("s4_addr200", imem_addr, 32'h200);
    check("s4_mis_on", misaligned, 1'b1);
    check("s4_valid_e5", if_valid, 1'b0);
    check("s4_inst_e5", inst, 32'h0);
    tick(); // E6
    check("s4_mis_off", misaligned, 1'b0);
    check("s4_valid_e6", if_valid, 1'b0);
    tick(); // E7
    check("s4_pc200", id_pc, 32'h200);
    check("s4_inst200", inst, 32'h1000_0200);

    // ---- 5: if_rst with 2 buffered entries while stalled
    hold_reset();
    if_en = 1'b1;
    rst = 1'b1;
    tick(); tick(); tick(); // E1..E3
    check("s5_pc0", id_pc, 32'h0);
    if_en = 1'b0;
    tick(); // E4
    check("s5_idle", imem_req, 1'b0);
    check("s5_hold_valid", if_valid, 1'b1);
    tick(); // E5
    check("s5_hold_inst", inst, 32'h1000_0000);
    if_rst = 1'b1;
    tick(); // E6
    if_rst = 1'b0;
    check("s5_valid_fl", if_valid, 1'b0);
    check("s5_inst_fl", inst, 32'h0);
    check("s5_req_fl", imem_req, 1'b1);
    check("s5_addrC", imem_addr, 32'hC);
    if_en = 1'b1;
    tick(); // E7
    check("s5_empty", if_valid, 1'b0);
    tick(); // E8
    check("s5_pcC", id_pc, 32'hC);
    check("s5_instC", inst, 32'h1000_000C);

    // ---- 6: async reset mid-request at 0x40, stray ack after release
    lat = 3;
    hold_reset();
    redirect = 1'b1; redirect_pc = 32'h40;
    rst = 1'b1;
    tick(); // E1
    redirect = 1'b0; redirect_pc = 32'h0;
    check("s6_addr40", imem_addr, 32'h40);
    check("s6_req40", imem_req, 1'b1);
    tick(); // E2
    #2;
    rst = 1'b0;
    #1;
    check("s6_ar_req", imem_req, 1'b0);
    check("s6_ar_state", state_dbg, IF_IDLE);
    check("s6_ar_addr", imem_addr, 32'h0);
    check("s6_ar_valid", if_valid, 1'b0);
    check("s6_ar_pcn", id_pc_next, 32'h4);
    tick(); tick();
    lat = 0;
    rst = 1'b1; force_ack = 1'b1;
    tick(); // E1'
    force_ack = 1'b0;
    check("s6_req_rel", imem_req, 1'b1);
    check("s6_addr_rel", imem_addr, 32'h0);
    check("s6_valid_rel", if_valid, 1'b0);
    tick(); // E2'
    check("s6_stray", if_valid, 1'b0);
    check("s6_addr4", imem_addr, 32'h4);
    tick(); // E3'
    check("s6_pc0", id_pc, 32'h0);
    check("s6_inst0", inst, 32'h1000_0000);
    check("s6_valid0", if_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
